counter_ctrl: RTL
=================

# counter_ctrl

Command-side driver for the lab up/down counter (range 0..12, saturating, synchronous load). It turns raw push buttons and switches into the counter's `en`/`dir`/`load`/`data` control inputs and reads the counter's `out` value back. In auto mode it runs a ping-pong sweep between 0 and CNT_MAX. It sits between the board I/O and the counter: buttons and switches on one side, counter controls on the other.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button must stay high before it counts as pressed (≥1)
- TICK_DIV, 8, cycles between auto-mode steps (≥4)
- CNT_MAX, 12, counter upper limit
- DATA_W, 4, width of count and data

Ports (reset `rst` is asynchronous, active-high; clock is `clk`):
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- btn_up, in, 1, raw button, asynchronous
- btn_down, in, 1, raw button, asynchronous
- btn_load, in, 1, raw button, asynchronous
- sw_auto, in, 1, raw switch: 1 = auto sweep, 0 = manual
- sw_data, in, DATA_W, raw load value
- cnt, in, DATA_W, counter `out` readback
- en, out, 1, counter enable (one-cycle command pulse)
- dir, out, 1, 1 = up, 0 = down
- load, out, 1, load strobe, qualified by `en`
- data, out, DATA_W, load value
- err, out, 1, sticky out-of-range flag

## Operation
- Reset values:
  - `en` = 0, `dir` = 1, `load` = 0, `data` = 0, `err` = 0.
  - State is MANUAL and the tick counter is 0.
- Button path:
  - Each button passes through a 2-FF synchronizer.
  - A debounce counter clears on any low sample and saturates at DEBOUNCE_CYCLES.
  - The level is debounced-high while the counter equals DEBOUNCE_CYCLES.
  - A rising edge of the debounced level yields a one-cycle press pulse.
  - `sw_auto` uses a 2-FF synchronizer only, with no debounce.
- Commands: all outputs are registered, and `en` is high for exactly one cycle per command.
  - LOAD: `en` = 1, `load` = 1, `data` = min(sw_data, CNT_MAX).
  - UP: `en` = 1, `load` = 0, `dir` = 1.
  - DOWN: `en` = 1, `load` = 0, `dir` = 0.
  - `dir` and `data` hold their last values when idle.
- Priority within a cycle:
  - LOAD press beats everything.
  - An UP and DOWN press in the same cycle issues no command.
  - The auto tick loses to a LOAD press. When that happens, the tick counter restarts at 0.
- FSM states: MANUAL, AUTO_UP, AUTO_DOWN.
  - MANUAL: UP and DOWN presses issue commands. If synchronized `sw_auto` = 1, go to AUTO_UP and clear the tick counter.
  - AUTO_UP and AUTO_DOWN: the tick counter runs 0..TICK_DIV-1. At TICK_DIV-1 a step is issued.
    - In AUTO_UP: if `cnt` ≥ CNT_MAX, go to AUTO_DOWN and issue DOWN; otherwise issue UP.
    - AUTO_DOWN mirrors this: `cnt` = 0 turns it to AUTO_UP and issues UP.
    - UP and DOWN presses are ignored; LOAD is honored.
    - `sw_auto` = 0 returns to MANUAL on the next edge, clears the tick counter, and issues no further auto command.
- Saturation is the counter's job. The controller still issues UP at CNT_MAX in manual mode.

## Timing
- Button latency:
  - A raw button is first sampled high at edge k and held high.
  - The debounced level rises at edge k+1+DEBOUNCE_CYCLES.
  - `en` is high in the cycle following edge k+2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+3 edges counting edge k.
- A button held high gives one pulse. A new pulse needs release (at least one low synchronized sample) followed by a fresh stable period.
- Auto steps are exactly TICK_DIV cycles apart. `cnt` is sampled on the step edge; TICK_DIV ≥ 4 guarantees it has settled from the previous step.
- An `rst` assertion mid-operation immediately forces all reset values, including clearing debounce counters and synchronizers.
- `err` becomes valid 1 cycle after `cnt` is sampled.

## Configuration
- CNT_CTRL_RANGE_CHECK_EN defined:
  - `err` sets on any edge where `cnt` > CNT_MAX and stays set until `rst`.
  - In auto mode, a set `err` also forces MANUAL.
- CNT_CTRL_RANGE_CHECK_EN undefined: `err` is tied to 0 and no check logic is built.

## Structure
- Package `counter_pkg` holds CNT_MAX, DATA_W, the state enum (MANUAL/AUTO_UP/AUTO_DOWN), and the command encoding constants.
- Sub-module `btn_debounce` (synchronizer, debounce counter, one-pulse) is instantiated three times. Its only parameter is DEBOUNCE_CYCLES.

## Test plan
- Reset → `en` = 0, `dir` = 1, `load` = 0, `data` = 0, `err` = 0. Hold `btn_up` high 20 cycles → exactly one `en`/`dir` = 1 pulse, 7 edges after the first sample (DEBOUNCE_CYCLES = 4).
- Glitch `btn_down` high for 3 cycles, then low → no `en`. Hold it 10 cycles → one pulse with `dir` = 0.
- `sw_data` = 15, press `btn_load` → `en` = 1, `load` = 1, `data` = 12. Simultaneous UP and DOWN presses → no command.
- `sw_auto` = 1 with the counter model starting at 10 → UP, UP at 8-cycle spacing; `cnt` = 12 → DOWN steps to 0, then UP again. LOAD press mid-sweep loads, and the next step follows 8 cycles later.
- With the macro: drive `cnt` = 15 → `err` = 1 the next cycle, sticky, and state forced to MANUAL. Without the macro: `err` stays 0.
- Assert `rst` while a button is held and auto is active → all reset values; no pulse after release of `rst` until the button is re-debounced.

Source files
------------

// File: rtl/counter_pkg.sv
// +----------------------------------------------------------------------+
// | counter_pkg : shared constants, FSM states and command encoding for  |
// |               the counter command controller.                        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

  localparam int CNT_MAX = 12;
  localparam int DATA_W  = 4;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_LOAD = 2'd3
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/counter_ctrl_if.sv
// +----------------------------------------------------------------------+
// | counter_ctrl_if : board-side inputs and counter-side controls of the |
// |                   counter command controller.                        |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

interface counter_ctrl_if #(
  parameter int DATA_W = counter_pkg::DATA_W
);
  logic              btn_up;
  logic              btn_down;
  logic              btn_load;
  logic              sw_auto;
  logic [DATA_W-1:0] sw_data;
  logic [DATA_W-1:0] cnt;
  logic              en;
  logic              dir;
  logic              load;
  logic [DATA_W-1:0] data;
  logic              err;

  // master is the controller; slave is the board/counter environment
  modport master (
    input  btn_up, btn_down, btn_load, sw_auto, sw_data, cnt,
    output en, dir, load, data, err
  );

  modport slave (
    output btn_up, btn_down, btn_load, sw_auto, sw_data, cnt,
    input  en, dir, load, data, err
  );
endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------+
// | btn_debounce : 2-FF synchronizer, saturating debounce counter and    |
// |                one-cycle press pulse on the debounced rising edge.   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  btn,
  output logic press
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(DEBOUNCE_CYCLES);

  logic [1:0]         r_sync;
  logic [c_cnt_w-1:0] r_db_cnt;
  logic               r_level_q;
  logic               w_level;

  assign w_level = (r_db_cnt == c_cnt_top);
  assign press   = w_level & ~r_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_db_cnt  <= '0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn};
      r_level_q <= w_level;
      if (!r_sync[1])
        r_db_cnt <= '0;
      else if (r_db_cnt != c_cnt_top)
        r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// +----------------------------------------------------------------------+
// | counter_ctrl : button/switch front end and ping-pong auto sweep that |
// |                drives the lab up/down counter's en/dir/load/data.    |
// |                CNT_CTRL_RANGE_CHECK_EN builds the sticky err check.  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8,
  parameter int CNT_MAX         = counter_pkg::CNT_MAX,
  parameter int DATA_W          = counter_pkg::DATA_W
) (
  input wire             clk,
  input wire             rst,
  counter_ctrl_if.master bus
);
  import counter_pkg::*;

  localparam int                 c_tick_w    = $clog2(TICK_DIV);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [DATA_W-1:0]  c_cnt_max   = DATA_W'(CNT_MAX);

  logic                w_press_up, w_press_down, w_press_load;
  logic [1:0]          r_auto_sync;
  logic                w_auto;
  logic                w_err;

  state_t              r_state, w_state_nxt;
  logic [c_tick_w-1:0] r_tick, w_tick_nxt;
  cmd_t                w_cmd;
  logic                r_en, r_dir, r_load;
  logic [DATA_W-1:0]   r_data;
  logic                w_dir_nxt;
  logic [DATA_W-1:0]   w_data_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn(bus.btn_up), .press(w_press_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn(bus.btn_down), .press(w_press_down)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst(rst), .btn(bus.btn_load), .press(w_press_load)
  );

  assign w_auto = r_auto_sync[1];

`ifdef CNT_CTRL_RANGE_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (bus.cnt > c_cnt_max)
      r_err <= 1'b1;
  end
  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_cmd       = CMD_NONE;
    case (r_state)
      MANUAL: begin
        if (w_press_load)
          w_cmd = CMD_LOAD;
        else if (w_press_up && !w_press_down)
          w_cmd = CMD_UP;
        else if (w_press_down && !w_press_up)
          w_cmd = CMD_DOWN;
        // a latched range error keeps the sweep from restarting
        if (w_auto && !w_err) begin
          w_state_nxt = AUTO_UP;
          w_tick_nxt  = '0;
        end
      end
      default: begin
        if (!w_auto || w_err) begin
          w_state_nxt = MANUAL;
          w_tick_nxt  = '0;
          if (w_press_load)
            w_cmd = CMD_LOAD;
        end else if (w_press_load) begin
          w_cmd      = CMD_LOAD;
          w_tick_nxt = '0;
        end else if (r_tick == c_tick_last) begin
          w_tick_nxt = '0;
          if (r_state == AUTO_UP) begin
            if (bus.cnt >= c_cnt_max) begin
              w_state_nxt = AUTO_DOWN;
              w_cmd       = CMD_DOWN;
            end else begin
              w_cmd = CMD_UP;
            end
          end else begin
            if (bus.cnt == '0) begin
              w_state_nxt = AUTO_UP;
              w_cmd       = CMD_UP;
            end else begin
              w_cmd = CMD_DOWN;
            end
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
    endcase

    w_dir_nxt  = r_dir;
    w_data_nxt = r_data;
    case (w_cmd)
      CMD_UP:   w_dir_nxt = 1'b1;
      CMD_DOWN: w_dir_nxt = 1'b0;
      CMD_LOAD: w_data_nxt = (bus.sw_data > c_cnt_max) ? c_cnt_max : bus.sw_data;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto_sync <= 2'b00;
      r_state     <= MANUAL;
      r_tick      <= '0;
      r_en        <= 1'b0;
      r_dir       <= 1'b1;
      r_load      <= 1'b0;
      r_data      <= '0;
    end else begin
      r_auto_sync <= {r_auto_sync[0], bus.sw_auto};
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_en        <= (w_cmd != CMD_NONE);
      r_load      <= (w_cmd == CMD_LOAD);
      r_dir       <= w_dir_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign bus.en   = r_en;
  assign bus.dir  = r_dir;
  assign bus.load = r_load;
  assign bus.data = r_data;
  assign bus.err  = w_err;

endmodule

`default_nettype wire
